// File: rtl/alu_pkg.sv
// Shared types and funct encodings for the ALU issue stage and its FIFO.
// issue_entry_t is sized for the default 32-bit datapath with 5-bit register tags.
package alu_pkg;

   localparam int ISSUE_DATA_W = 32;
   localparam int ISSUE_TAG_W  = 5;

   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   typedef struct packed {
      logic [ISSUE_DATA_W-1:0] a;
      logic [ISSUE_DATA_W-1:0] b;
      logic [5:0]              funct;
      logic [ISSUE_TAG_W-1:0]  rs;
      logic [ISSUE_TAG_W-1:0]  rt;
      logic [ISSUE_TAG_W-1:0]  rd;
   } issue_entry_t;

   function automatic logic funct_is_legal(input logic [5:0] funct);
      return funct inside {FUNCT_AND, FUNCT_OR, FUNCT_ADD, FUNCT_SUB, FUNCT_SLT};
   endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Synchronous FIFO of issue_entry_t; pop data is the head entry, visible combinationally.
// Push is ignored when full and pop is ignored when empty.
module alu_issue_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  issue_entry_t             push_data,
   input  logic                     pop,
   output issue_entry_t             pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   issue_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand issue stage ahead of the ALU: FIFO buffering, result forwarding, hold-until-writeback.
// Optional macro ALU_FUNCT_CHECK_EN drops unsupported funct codes at issue and pulses illegal.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int TAG_W      = 5,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [5:0]        in_funct,
   input  logic [TAG_W-1:0]  in_rs,
   input  logic [TAG_W-1:0]  in_rt,
   input  logic [TAG_W-1:0]  in_rd,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [5:0]        alu_funct,
   output logic [TAG_W-1:0]  alu_rd,
   output logic              alu_valid,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              wb_ready,
   output logic              illegal
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   issue_entry_t      in_entry;
   issue_entry_t      head;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic              retire;
   logic              issue;
   logic [DATA_W-1:0] fwd_a;
   logic [DATA_W-1:0] fwd_b;
   logic              ret_vld;
   logic [DATA_W-1:0] ret_data;
   logic [TAG_W-1:0]  ret_rd;

   assign in_entry = '{a: in_a, b: in_b, funct: in_funct, rs: in_rs, rt: in_rt, rd: in_rd};

   // in_ready comes straight from the FIFO count register, never from in_valid.
   assign in_ready  = !fifo_full;
   assign fifo_push = in_valid && in_ready;
   assign retire    = alu_valid && wb_ready;
   assign fifo_pop  = !fifo_empty && (!alu_valid || wb_ready);

   alu_issue_fifo #(
      .DEPTH     (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (in_entry),
      .pop       (fifo_pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // A live ALU op at issue time is necessarily retiring, so its result is the freshest value.
   always_comb begin
      fwd_a = head.a;
      fwd_b = head.b;
      if (head.rs != '0) begin
         if (alu_valid && alu_rd == head.rs)     fwd_a = alu_result;
         else if (ret_vld && ret_rd == head.rs)  fwd_a = ret_data;
      end
      if (head.rt != '0) begin
         if (alu_valid && alu_rd == head.rt)     fwd_b = alu_result;
         else if (ret_vld && ret_rd == head.rt)  fwd_b = ret_data;
      end
   end

`ifdef ALU_FUNCT_CHECK_EN
   logic illegal_q;

   assign issue   = fifo_pop && funct_is_legal(head.funct);
   assign illegal = illegal_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) illegal_q <= 1'b0;
      else        illegal_q <= fifo_pop && !funct_is_legal(head.funct);
   end
`else
   assign issue   = fifo_pop;
   assign illegal = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a     <= '0;
         alu_b     <= '0;
         alu_funct <= '0;
         alu_rd    <= '0;
         alu_valid <= 1'b0;
      end else if (issue) begin
         alu_a     <= fwd_a;
         alu_b     <= fwd_b;
         alu_funct <= head.funct;
         alu_rd    <= head.rd;
         alu_valid <= 1'b1;
      end else if (retire) begin
         alu_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ret_vld  <= 1'b0;
         ret_data <= '0;
         ret_rd   <= '0;
      end else if (retire) begin
         ret_vld  <= 1'b1;
         ret_data <= alu_result;
         ret_rd   <= alu_rd;
      end
   end

   full_matches_count: assert property (@(posedge clk) disable iff (!rst_n)
      fifo_full == (fifo_count == CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: queue-based operand model checked every cycle plus directed literal checks.
module tb_alu_issue_stage;
   import alu_pkg::*;

   localparam int DW    = 32;
   localparam int TW    = 5;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_a = '0, in_b = '0;
   logic [5:0]    in_funct = '0;
   logic [TW-1:0] in_rs = '0, in_rt = '0, in_rd = '0;
   logic [DW-1:0] alu_a, alu_b, alu_result;
   logic [5:0]    alu_funct;
   logic [TW-1:0] alu_rd;
   logic          alu_valid;
   logic          wb_ready = 1'b1;
   logic          illegal;

   int vec  = 0;
   int errs = 0;
   int ill_cnt = 0;

   always #5 clk = ~clk;

   alu_issue_stage #(.DATA_W(DW), .TAG_W(TW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_funct(in_funct), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .alu_a(alu_a), .alu_b(alu_b), .alu_funct(alu_funct), .alu_rd(alu_rd), .alu_valid(alu_valid),
      .alu_result(alu_result), .wb_ready(wb_ready), .illegal(illegal)
   );

   function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
      case (f)
         FUNCT_AND: return a & b;
         FUNCT_OR:  return a | b;
         FUNCT_ADD: return a + b;
         FUNCT_SUB: return a - b;
         FUNCT_SLT: return {31'b0, $signed(a) < $signed(b)};
         default:   return 32'h0;
      endcase
   endfunction

   assign alu_result = alu_fn(alu_a, alu_b, alu_funct);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] a, b;
      logic [5:0]  f;
      logic [4:0]  rs, rt, rd;
   } op_t;

   op_t         q[$];
   bit          m_vld;
   op_t         m_cur;
   bit          r_vld;
   logic [31:0] r_data;
   logic [4:0]  r_rd;
   bit          m_ill;

   function automatic bit legal(input logic [5:0] f);
`ifdef ALU_FUNCT_CHECK_EN
      return f inside {FUNCT_AND, FUNCT_OR, FUNCT_ADD, FUNCT_SUB, FUNCT_SLT};
`else
      return (f == f);
`endif
   endfunction

   // Newest known value of a register: the op in the ALU, else the last retired result, else decode's copy.
   function automatic logic [31:0] pick(input logic [4:0] tag, input logic [31:0] val);
      if (tag == 0) return val;
      if (m_vld && m_cur.rd == tag) return alu_fn(m_cur.a, m_cur.b, m_cur.f);
      if (r_vld && r_rd == tag) return r_data;
      return val;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_vld = 0; m_cur = '0; r_vld = 0; r_data = '0; r_rd = '0; m_ill = 0;
      end else begin
         bit          ret, do_push;
         op_t         h, nxt;
         logic [31:0] res;
         logic [4:0]  old_rd;
         res     = alu_fn(m_cur.a, m_cur.b, m_cur.f);
         old_rd  = m_cur.rd;
         ret     = m_vld && wb_ready;
         do_push = in_valid && (q.size() < DEPTH);
         m_ill   = 0;
         if (q.size() > 0 && (!m_vld || wb_ready)) begin
            h = q.pop_front();
            if (legal(h.f)) begin
               nxt   = h;
               nxt.a = pick(h.rs, h.a);
               nxt.b = pick(h.rt, h.b);
               m_cur = nxt;
               m_vld = 1;
            end else begin
               m_ill = 1;
               if (ret) m_vld = 0;
            end
         end else if (ret) begin
            m_vld = 0;
         end
         if (ret) begin
            r_vld = 1; r_data = res; r_rd = old_rd;
         end
         if (do_push) q.push_back('{a: in_a, b: in_b, f: in_funct, rs: in_rs, rt: in_rt, rd: in_rd});
      end
   end

   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         chk("in_ready", in_ready, (q.size() < DEPTH));
         chk("alu_valid", alu_valid, m_vld);
         chk("illegal", illegal, m_ill);
         if (m_vld) begin
            chk("alu_a", alu_a, m_cur.a);
            chk("alu_b", alu_b, m_cur.b);
            chk("alu_funct", alu_funct, m_cur.f);
            chk("alu_rd", alu_rd, m_cur.rd);
         end
         if (illegal) ill_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      bit ok = 0;
      in_valid = 1; in_a = a; in_b = b; in_funct = f; in_rs = rs; in_rt = rt; in_rd = rd;
      for (int i = 0; i < 40; i++) begin
         bit acc;
         acc = in_ready;
         @(negedge clk);
         if (acc) begin ok = 1; break; end
      end
      in_valid = 0;
      if (!ok) begin
         vec++; errs++;
         $display("FAIL push_timeout: op rd=%0d not accepted, expected acceptance within 40 cycles", rd);
      end
   endtask

   task automatic wait_issue(input logic [4:0] rd, input logic [5:0] f);
      bit ok = 0;
      for (int i = 0; i < 40; i++) begin
         if (alu_valid && alu_rd == rd && alu_funct == f) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         vec++; errs++;
         $display("FAIL issue_timeout: op rd=%0d never issued, expected issue within 40 cycles", rd);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_alu_valid", alu_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_illegal", illegal, 0);
      rst_n = 1;
      @(negedge clk);
      chk("idle_alu_valid", alu_valid, 0);
      chk("idle_in_ready", in_ready, 1);

      // single ADD: enqueue edge N, issue edge N+1
      push_op(5, 7, FUNCT_ADD, 1, 2, 3);
      chk("lat_not_yet", alu_valid, 0);
      @(negedge clk);
      chk("lat_valid", alu_valid, 1);
      chk("add_funct", alu_funct, 6'b100000);
      chk("add_a", alu_a, 5);
      chk("add_b", alu_b, 7);
      chk("add_rd", alu_rd, 3);
      @(negedge clk);
      chk("add_retired", alu_valid, 0);

      // dependent op forwarded from the retiring ALU result
      push_op(5, 7, FUNCT_ADD, 1, 2, 4);
      push_op(0, 2, FUNCT_SUB, 4, 0, 5);
      wait_issue(5, FUNCT_SUB);
      chk("fwd_alu_a", alu_a, 12);
      chk("fwd_alu_b", alu_b, 2);

      // forward from the retired-result register after a gap
      push_op(32'hF0, 32'h0F, FUNCT_ADD, 1, 2, 9);
      repeat (4) @(negedge clk);
      push_op(32'h100, 0, FUNCT_OR, 0, 9, 10);
      wait_issue(10, FUNCT_OR);
      chk("fwd_ret_b", alu_b, 32'hFF);
      chk("fwd_ret_a", alu_a, 32'h100);

      // tag 0 is never forwarded
      push_op(1, 1, FUNCT_ADD, 2, 2, 0);
      push_op(32'h33, 4, FUNCT_ADD, 0, 0, 7);
      wait_issue(7, FUNCT_ADD);
      chk("zero_tag_a", alu_a, 32'h33);
      repeat (3) @(negedge clk);

      // backpressure: FIFO fills behind a held op
      wb_ready = 0;
      push_op(32'h11, 32'h1, FUNCT_ADD, 0, 0, 11);
      push_op(32'h22, 32'h2, FUNCT_SUB, 0, 0, 12);
      push_op(32'h44, 32'h3, FUNCT_OR, 0, 0, 13);
      chk("bp_in_ready_low", in_ready, 0);
      for (int i = 0; i < 4; i++) begin
         chk("bp_hold_valid", alu_valid, 1);
         chk("bp_hold_a", alu_a, 32'h11);
         chk("bp_hold_rd", alu_rd, 11);
         @(negedge clk);
      end
      wb_ready = 1;
      wait_issue(12, FUNCT_SUB);
      chk("bp_b_a", alu_a, 32'h22);
      @(negedge clk);
      chk("bp_c_valid", alu_valid, 1);
      chk("bp_c_rd", alu_rd, 13);
      @(negedge clk);
      chk("bp_drained", alu_valid, 0);

      // funct 000000 between two ADDs
      push_op(1, 2, FUNCT_ADD, 0, 0, 14);
      push_op(3, 4, 6'b000000, 0, 0, 15);
      push_op(5, 6, FUNCT_ADD, 0, 0, 16);
`ifdef ALU_FUNCT_CHECK_EN
      wait_issue(16, FUNCT_ADD);
      chk("chk_add2_a", alu_a, 5);
      repeat (2) @(negedge clk);
      chk("illegal_pulses", ill_cnt, 1);
`else
      wait_issue(15, 6'b000000);
      chk("nochk_valid", alu_valid, 1);
      chk("nochk_a", alu_a, 3);
      wait_issue(16, FUNCT_ADD);
      repeat (2) @(negedge clk);
      chk("nochk_no_illegal", ill_cnt, 0);
`endif

      // asynchronous reset in the middle of a stalled stream
      wb_ready = 0;
      push_op(32'h55, 1, FUNCT_ADD, 0, 0, 17);
      push_op(32'h66, 1, FUNCT_ADD, 0, 0, 18);
      rst_n = 0;
      #1;
      chk("mid_rst_valid", alu_valid, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_a", alu_a, 0);
      @(negedge clk);
      rst_n = 1;
      wb_ready = 1;
      repeat (3) @(negedge clk);
      chk("post_rst_empty", alu_valid, 0);
      push_op(32'h77, 32'h8, FUNCT_SUB, 18, 17, 19);
      wait_issue(19, FUNCT_SUB);
      chk("post_rst_no_fwd_a", alu_a, 32'h77);
      chk("post_rst_no_fwd_b", alu_b, 32'h8);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
